qpu_lsu_agu: RTL and testbench

//  Address-generation stage directly upstream of the LSU control block. Accepts one load/store
//  per handshake from dispatch, computes addr = rs1 + imm, builds the byte write-mask and lane-

---
 rtl/qpu_lsu_agu_pkg.sv | 17 +
 rtl/qpu_lsu_agu_lanes.sv | 54 +++++
 rtl/qpu_lsu_agu.sv | 121 ++++++++++++
 tb/tb_qpu_lsu_agu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_lsu_agu_pkg.sv
// Shared size encodings, FSM state codes and helpers for the LSU address-generation stage.
package qpu_lsu_agu_pkg;

   localparam logic [1:0] QPU_LSU_SIZE_B = 2'b00;
   localparam logic [1:0] QPU_LSU_SIZE_H = 2'b01;
   localparam logic [1:0] QPU_LSU_SIZE_W = 2'b10;

   localparam logic [1:0] AGU_ST_IDLE = 2'b00;
   localparam logic [1:0] AGU_ST_CMD  = 2'b01;
   localparam logic [1:0] AGU_ST_EXCP = 2'b10;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] agu_norm_size(input logic [1:0] size);
      return (size == 2'b11) ? QPU_LSU_SIZE_W : size;
   endfunction

endpackage

// File: rtl/qpu_lsu_agu_lanes.sv
// Combinational byte-lane mask, replicated store data and alignment decode for one access.
// QPU_AGU_MISALGN_CHK_EN: flag misaligned accesses; otherwise low address bits are forced aligned.
module qpu_lsu_agu_lanes
   import qpu_lsu_agu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic [1:0]        size,
   input  logic              load,
   input  logic [AW-1:0]     addr_raw,
   input  logic [XLEN-1:0]   rs2,
   output logic [AW-1:0]     addr,
   output logic [XLEN/8-1:0] wmask,
   output logic [XLEN-1:0]   wdata,
   output logic              misaligned
);

   localparam int MW = XLEN / 8;

   logic [1:0] sz;

   always_comb begin
      sz         = agu_norm_size(size);
      addr       = addr_raw;
      misaligned = 1'b0;
`ifdef QPU_AGU_MISALGN_CHK_EN
      misaligned = ((sz == QPU_LSU_SIZE_H) & addr_raw[0]) |
                   ((sz == QPU_LSU_SIZE_W) & (|addr_raw[1:0]));
`else
      if (sz == QPU_LSU_SIZE_H) begin
         addr[0] = 1'b0;
      end else if (sz == QPU_LSU_SIZE_W) begin
         addr[1:0] = 2'b00;
      end
`endif

      wmask = '0;
      if (!load) begin
         case (sz)
            QPU_LSU_SIZE_B: wmask = {{(MW-1){1'b0}}, 1'b1} << addr[1:0];
            QPU_LSU_SIZE_H: wmask = {{(MW-2){1'b0}}, 2'b11} << {addr[1], 1'b0};
            default:        wmask = '1;
         endcase
      end

      case (sz)
         QPU_LSU_SIZE_B: wdata = {(XLEN/8){rs2[7:0]}};
         QPU_LSU_SIZE_H: wdata = {(XLEN/16){rs2[15:0]}};
         default:        wdata = rs2;
      endcase
   end

endmodule

// File: rtl/qpu_lsu_agu.sv
// Load/store address generation: addr = rs1 + imm, lane mask/data, alignment check, ICB cmd out.
// Latency 1 (all outputs registered); one request per 2 cycles; dispatch stalled until cmd/excp taken.
// QPU_AGU_MISALGN_CHK_EN enables the misaligned-exception path; default build has no exceptions.
module qpu_lsu_agu
   import qpu_lsu_agu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 32,
   parameter int TW   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              agu_i_valid,
   output logic              agu_i_ready,
   input  logic [XLEN-1:0]   agu_i_rs1,
   input  logic [XLEN-1:0]   agu_i_imm,
   input  logic [XLEN-1:0]   agu_i_rs2,
   input  logic              agu_i_load,
   input  logic [1:0]        agu_i_size,
   input  logic [TW-1:0]     agu_i_itag,
   output logic              agu_icb_cmd_valid,
   input  logic              agu_icb_cmd_ready,
   output logic [AW-1:0]     agu_icb_cmd_addr,
   output logic              agu_icb_cmd_read,
   output logic [XLEN-1:0]   agu_icb_cmd_wdata,
   output logic [XLEN/8-1:0] agu_icb_cmd_wmask,
   output logic [TW-1:0]     agu_icb_cmd_itag,
   output logic              agu_excp_valid,
   input  logic              agu_excp_ready,
   output logic [AW-1:0]     agu_excp_badaddr,
   output logic              agu_excp_ld,
   output logic [TW-1:0]     agu_excp_itag,
   output logic              agu_active
);

   logic [1:0]        state;
   logic [XLEN-1:0]   sum;
   logic [AW-1:0]     addr_raw;
   logic [AW-1:0]     addr_nxt;
   logic [XLEN/8-1:0] wmask_nxt;
   logic [XLEN-1:0]   wdata_nxt;
   logic              misaligned;
   logic              accept;

   logic [AW-1:0]     addr_q;
   logic              read_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN/8-1:0] wmask_q;
   logic [TW-1:0]     itag_q;

   assign sum      = agu_i_rs1 + agu_i_imm;
   assign addr_raw = sum[AW-1:0];
   assign accept   = agu_i_valid & (state == AGU_ST_IDLE);

   qpu_lsu_agu_lanes #(
      .XLEN (XLEN),
      .AW   (AW)
   ) u_lanes (
      .size       (agu_i_size),
      .load       (agu_i_load),
      .addr_raw   (addr_raw),
      .rs2        (agu_i_rs2),
      .addr       (addr_nxt),
      .wmask      (wmask_nxt),
      .wdata      (wdata_nxt),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= AGU_ST_IDLE;
      end else begin
         case (state)
            AGU_ST_IDLE: if (agu_i_valid) state <= misaligned ? AGU_ST_EXCP : AGU_ST_CMD;
            AGU_ST_CMD:  if (agu_icb_cmd_ready) state <= AGU_ST_IDLE;
            AGU_ST_EXCP: if (agu_excp_ready) state <= AGU_ST_IDLE;
            default:     state <= AGU_ST_IDLE;
         endcase
      end
   end

   // Payload only loads in IDLE, so it stays stable for as long as a handshake is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         read_q  <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         itag_q  <= '0;
      end else if (accept) begin
         addr_q  <= addr_nxt;
         read_q  <= agu_i_load;
         wdata_q <= wdata_nxt;
         wmask_q <= wmask_nxt;
         itag_q  <= agu_i_itag;
      end
   end

   assign agu_i_ready       = (state == AGU_ST_IDLE);
   assign agu_active        = agu_i_valid | (state != AGU_ST_IDLE);

   assign agu_icb_cmd_valid = (state == AGU_ST_CMD);
   assign agu_icb_cmd_addr  = addr_q;
   assign agu_icb_cmd_read  = read_q;
   assign agu_icb_cmd_wdata = wdata_q;
   assign agu_icb_cmd_wmask = wmask_q;
   assign agu_icb_cmd_itag  = itag_q;

`ifdef QPU_AGU_MISALGN_CHK_EN
   assign agu_excp_valid    = (state == AGU_ST_EXCP);
   assign agu_excp_badaddr  = addr_q;
   assign agu_excp_ld       = read_q;
   assign agu_excp_itag     = itag_q;
`else
   assign agu_excp_valid    = 1'b0;
   assign agu_excp_badaddr  = '0;
   assign agu_excp_ld       = 1'b0;
   assign agu_excp_itag     = '0;
`endif

endmodule

// File: tb/tb_qpu_lsu_agu.sv
// Scoreboard bench for qpu_lsu_agu; follows QPU_AGU_MISALGN_CHK_EN the same way the design does.
module tb_qpu_lsu_agu;

   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          agu_i_valid;
   logic          agu_i_ready;
   logic [31:0]   agu_i_rs1, agu_i_imm, agu_i_rs2;
   logic          agu_i_load;
   logic [1:0]    agu_i_size;
   logic [TW-1:0] agu_i_itag;
   logic          agu_icb_cmd_valid, agu_icb_cmd_ready;
   logic [31:0]   agu_icb_cmd_addr;
   logic          agu_icb_cmd_read;
   logic [31:0]   agu_icb_cmd_wdata;
   logic [3:0]    agu_icb_cmd_wmask;
   logic [TW-1:0] agu_icb_cmd_itag;
   logic          agu_excp_valid, agu_excp_ready;
   logic [31:0]   agu_excp_badaddr;
   logic          agu_excp_ld;
   logic [TW-1:0] agu_excp_itag;
   logic          agu_active;

   always #5 clk = ~clk;

   qpu_lsu_agu #(.XLEN(32), .AW(32), .TW(TW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .agu_i_valid       (agu_i_valid),
      .agu_i_ready       (agu_i_ready),
      .agu_i_rs1         (agu_i_rs1),
      .agu_i_imm         (agu_i_imm),
      .agu_i_rs2         (agu_i_rs2),
      .agu_i_load        (agu_i_load),
      .agu_i_size        (agu_i_size),
      .agu_i_itag        (agu_i_itag),
      .agu_icb_cmd_valid (agu_icb_cmd_valid),
      .agu_icb_cmd_ready (agu_icb_cmd_ready),
      .agu_icb_cmd_addr  (agu_icb_cmd_addr),
      .agu_icb_cmd_read  (agu_icb_cmd_read),
      .agu_icb_cmd_wdata (agu_icb_cmd_wdata),
      .agu_icb_cmd_wmask (agu_icb_cmd_wmask),
      .agu_icb_cmd_itag  (agu_icb_cmd_itag),
      .agu_excp_valid    (agu_excp_valid),
      .agu_excp_ready    (agu_excp_ready),
      .agu_excp_badaddr  (agu_excp_badaddr),
      .agu_excp_ld       (agu_excp_ld),
      .agu_excp_itag     (agu_excp_itag),
      .agu_active        (agu_active)
   );

   typedef struct {
      logic          excp;
      logic [31:0]   addr;
      logic          rd;
      logic [31:0]   wdata;
      logic [3:0]    wmask;
      logic [TW-1:0] itag;
   } exp_t;

   exp_t          sb[$];
   int            vectors = 0;
   int            miscompares = 0;
   bit            force_stall = 1'b0;
   bit            rnd = 1'b0;
   logic [TW-1:0] tag_ctr = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] rs1, input logic [31:0] imm,
                                  input logic [31:0] rs2, input logic ld,
                                  input logic [1:0] size, input logic [TW-1:0] itag);
      exp_t       e;
      logic [1:0] sz;
      logic [31:0] a;
      logic       mis;
      a   = rs1 + imm;
      sz  = (size == 2'd3) ? 2'd2 : size;
      mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0));
`ifdef QPU_AGU_MISALGN_CHK_EN
      e.excp = mis;
`else
      e.excp = 1'b0;
      if (mis) a = (sz == 2'd1) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
`endif
      e.addr = a;
      e.rd   = ld;
      e.itag = itag;
      case (sz)
         2'd0:    e.wdata = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
         2'd1:    e.wdata = {rs2[15:0], rs2[15:0]};
         default: e.wdata = rs2;
      endcase
      if (ld)             e.wmask = 4'h0;
      else if (sz == 2'd2) e.wmask = 4'hF;
      else if (sz == 2'd1) e.wmask = a[1] ? 4'b1100 : 4'b0011;
      else case (a[1:0])
         2'd0:    e.wmask = 4'b0001;
         2'd1:    e.wmask = 4'b0010;
         2'd2:    e.wmask = 4'b0100;
         default: e.wmask = 4'b1000;
      endcase
      return e;
   endfunction

   // Downstream readiness: held low for stall tests, randomised during the soak.
   initial begin
      agu_icb_cmd_ready = 1'b1;
      agu_excp_ready    = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (force_stall) begin
            agu_icb_cmd_ready = 1'b0;
            agu_excp_ready    = 1'b0;
         end else if (rnd) begin
            agu_icb_cmd_ready = 1'($urandom_range(0, 1));
            agu_excp_ready    = 1'($urandom_range(0, 1));
         end else begin
            agu_icb_cmd_ready = 1'b1;
            agu_excp_ready    = 1'b1;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ((agu_icb_cmd_valid && agu_icb_cmd_ready) || (agu_excp_valid && agu_excp_ready))) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("kind_excp", agu_excp_valid, e.excp);
               chk("valid_onehot", agu_icb_cmd_valid & agu_excp_valid, 0);
               if (e.excp) begin
                  chk("excp_badaddr", agu_excp_badaddr, e.addr);
                  chk("excp_ld", agu_excp_ld, e.rd);
                  chk("excp_itag", agu_excp_itag, e.itag);
               end else begin
                  chk("cmd_addr", agu_icb_cmd_addr, e.addr);
                  chk("cmd_read", agu_icb_cmd_read, e.rd);
                  chk("cmd_wdata", agu_icb_cmd_wdata, e.wdata);
                  chk("cmd_wmask", agu_icb_cmd_wmask, e.wmask);
                  chk("cmd_itag", agu_icb_cmd_itag, e.itag);
               end
            end
         end
      end
   end

   // Returns at the negedge one cycle after acceptance, i.e. while the output is first presented.
   task automatic send(input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                       input logic ld, input logic [1:0] size);
      bit accepted = 1'b0;
      @(posedge clk); #1;
      agu_i_valid = 1'b1;
      agu_i_rs1   = rs1;
      agu_i_imm   = imm;
      agu_i_rs2   = rs2;
      agu_i_load  = ld;
      agu_i_size  = size;
      agu_i_itag  = tag_ctr;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (agu_i_ready) begin
            sb.push_back(model(rs1, imm, rs2, ld, size, tag_ctr));
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      agu_i_valid = 1'b0;
      tag_ctr++;
      @(negedge clk);
      chk("latency_valid", agu_icb_cmd_valid | agu_excp_valid, 1);
      chk("busy_not_ready", agu_i_ready, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      agu_i_valid = 1'b0;
      agu_i_rs1   = '0;
      agu_i_imm   = '0;
      agu_i_rs2   = '0;
      agu_i_load  = 1'b0;
      agu_i_size  = 2'b00;
      agu_i_itag  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_ready", agu_i_ready, 1);
      chk("rst_cmd_valid", agu_icb_cmd_valid, 0);
      chk("rst_excp_valid", agu_excp_valid, 0);
      chk("rst_cmd_addr", agu_icb_cmd_addr, 0);
      chk("rst_cmd_wmask", agu_icb_cmd_wmask, 0);
      chk("rst_excp_badaddr", agu_excp_badaddr, 0);
      chk("rst_active", agu_active, 0);
      rst_n = 1'b1;

      send(32'h100, 32'h8, 32'hA5A5_1234, 1'b0, 2'b10);
      chk("word_st_addr", agu_icb_cmd_addr, 32'h108);
      chk("word_st_wmask", agu_icb_cmd_wmask, 4'hF);
      chk("word_st_read", agu_icb_cmd_read, 0);
      chk("word_st_wdata", agu_icb_cmd_wdata, 32'hA5A5_1234);

      send(32'h100, 32'h3, 32'h77, 1'b0, 2'b00);
      chk("byte_st_addr", agu_icb_cmd_addr, 32'h103);
      chk("byte_st_wmask", agu_icb_cmd_wmask, 4'b1000);
      chk("byte_st_wdata", agu_icb_cmd_wdata, 32'h7777_7777);

      send(32'h100, 32'h2, 32'h0, 1'b1, 2'b01);
      chk("half_ld_wmask", agu_icb_cmd_wmask, 4'h0);
      chk("half_ld_read", agu_icb_cmd_read, 1);

      send(32'h200, 32'h2, 32'h0000_BEEF, 1'b0, 2'b01);
      chk("half_st_wmask", agu_icb_cmd_wmask, 4'b1100);
      chk("half_st_wdata", agu_icb_cmd_wdata, 32'hBEEF_BEEF);

      send(32'h100, 32'h1, 32'h0, 1'b1, 2'b10);
`ifdef QPU_AGU_MISALGN_CHK_EN
      chk("misal_excp_valid", agu_excp_valid, 1);
      chk("misal_badaddr", agu_excp_badaddr, 32'h101);
      chk("misal_ld", agu_excp_ld, 1);
      chk("misal_cmd_valid", agu_icb_cmd_valid, 0);
`else
      chk("misal_cmd_addr", agu_icb_cmd_addr, 32'h100);
      chk("misal_excp_valid", agu_excp_valid, 0);
      chk("misal_excp_badaddr", agu_excp_badaddr, 0);
`endif

      send(32'hFFFF_FFFC, 32'h8, 32'h1, 1'b1, 2'b10);
      chk("wrap_addr", agu_icb_cmd_addr, 32'h4);

      send(32'h100, 32'h2, 32'h1357_9BDF, 1'b0, 2'b11);
`ifdef QPU_AGU_MISALGN_CHK_EN
      chk("size3_excp", agu_excp_valid, 1);
      chk("size3_ld", agu_excp_ld, 0);
`else
      chk("size3_addr", agu_icb_cmd_addr, 32'h100);
      chk("size3_wmask", agu_icb_cmd_wmask, 4'hF);
`endif
      drain();

      force_stall = 1'b1;
      @(posedge clk);
      send(32'h300, 32'h10, 32'hCAFE_F00D, 1'b0, 2'b10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", agu_icb_cmd_valid, 1);
         chk("stall_addr", agu_icb_cmd_addr, 32'h310);
         chk("stall_wdata", agu_icb_cmd_wdata, 32'hCAFE_F00D);
         chk("stall_wmask", agu_icb_cmd_wmask, 4'hF);
         chk("stall_i_ready", agu_i_ready, 0);
      end
      force_stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("stall_release_ready", agu_i_ready, 1);
      chk("stall_release_valid", agu_icb_cmd_valid, 0);
      chk("stall_drained", sb.size(), 0);

      rnd = 1'b1;
      for (int n = 0; n < 40; n++) begin
         send($urandom, 32'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      rnd = 1'b0;
      drain();

      force_stall = 1'b1;
      @(posedge clk);
      send(32'h400, 32'h4, 32'h1111_2222, 1'b0, 2'b10);
      chk("rst_mid_active", agu_active, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_cmd_valid", agu_icb_cmd_valid, 0);
      chk("rst_mid_excp_valid", agu_excp_valid, 0);
      chk("rst_mid_cmd_addr", agu_icb_cmd_addr, 0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      force_stall = 1'b0;
      @(negedge clk);
      chk("rst_mid_idle_ready", agu_i_ready, 1);
      chk("rst_mid_idle_valid", agu_icb_cmd_valid, 0);
      chk("rst_mid_idle_active", agu_active, 0);

      send(32'h500, 32'h0, 32'h0, 1'b1, 2'b10);
      chk("post_rst_addr", agu_icb_cmd_addr, 32'h500);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
